adc_udp_packer: RTL
===================

# adc_udp_packer

Multi-channel ADC-to-UDP frame packer in the 125 MHz Ethernet clock domain. It accepts synchronised sample vectors from CH_NUM ADC channels and buffers them channel-interleaved in a circular 16-bit word RAM. Once a full frame is buffered, it launches a UDP transmission and serves the UDP module's byte requests with a 4-byte header followed by big-endian samples. It is the parametrised successor of the single-channel, 8-bit, FIFO-count-triggered UDP control path.

## Interface
- CH_NUM, 2, channel count, 1..8
- SAMPLE_W, 10, sample width, 1..12; zero-extended to 16 bits
- FRAME_SAMPLES, 256, samples per channel per frame, ≥1
- BUF_AW, 11, RAM address width; 2^BUF_AW ≥ 2·CH_NUM·FRAME_SAMPLES

Ports:
- clk  in  1  125 MHz clock, sole clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable; sampled per s_valid
- s_valid  in  1  one-cycle strobe, sample vector present
- s_data  in  CH_NUM·SAMPLE_W  channel c at bits [c·SAMPLE_W +: SAMPLE_W]
- tx_start_en  out  1  one-cycle frame start pulse to UDP
- tx_byte_num  out  16  constant 4 + 2·CH_NUM·FRAME_SAMPLES
- tx_req  in  1  UDP byte request
- tx_data  out  8  byte for UDP
- tx_done  in  1  UDP frame complete pulse
- busy  out  1  FSM not in IDLE
- seq  out  16  frame sequence number
- ovf_cnt  out  16  dropped-vector count, saturating

## Operation
- Write side: on s_valid & en & serializer idle & free words ≥ CH_NUM:
  - capture s_data into a holding register;
  - write one word per cycle, channel 0 first, over CH_NUM cycles.
- Drop: s_valid & en while the serializer is busy or free < CH_NUM drops the whole vector and increments ovf_cnt (holds at 16'hFFFF). Partial vectors are never written.
- Pointers are BUF_AW+1 bits. level = wr_ptr − rd_ptr. full when level = 2^BUF_AW.
- FSM states and transitions:
  - IDLE → START when level ≥ CH_NUM·FRAME_SAMPLES.
  - START: tx_start_en high for one cycle → SEND.
  - SEND: serve tx_req until tx_byte_num bytes are issued → WAIT_DONE.
  - WAIT_DONE: on tx_done, seq += 1 (wraps) → IDLE.
  - A tx_done seen in SEND also goes to IDLE. The remaining frame words are skipped by advancing rd_ptr to the frame end.
- Byte order: 8'hA5, 8'h5A, seq[15:8], seq[7:0], then per word high byte then low byte. Words are in RAM order (sample 0 ch0, sample 0 ch1, …).
- rd_ptr advances one word per two payload bytes.
- tx_req beyond byte count, or outside SEND: ignored; tx_data = 8'h00.
- The write side keeps running during transmission.

## Timing
- Reset values:
  - tx_start_en 0, tx_data 0, busy 0, seq 0, ovf_cnt 0;
  - pointers 0; FSM IDLE; serializer idle.
  - tx_byte_num is constant.
- Write latency: word for channel c is written c+1 cycles after the accepted s_valid. The level includes the whole vector only after the last word is written.
- Minimum s_valid spacing without drop: CH_NUM cycles.
- tx_start_en asserts 2 cycles after the level crosses the threshold (1 cycle registered compare, 1 cycle START).
- Read handshake: tx_data for a tx_req cycle is valid on the next cycle. tx_req may be continuous. RAM read latency is hidden by prefetching the first word in START.
- Simultaneous write and read in one cycle: both pointers update; level is consistent.
- rst mid-frame: immediate return to reset values; the buffer content is discarded.

## Configuration
- ADC_UDP_PACKER_PATTERN_EN defined: s_data is ignored. Channel c word = {c[3:0], ramp[11:0]}. ramp is 0 at reset and increments once per accepted vector, wrapping at 4095. Capture, drop and framing rules are unchanged.
- Undefined: words are zero-extended s_data. No ramp logic is present.

## Test plan
Each scenario uses CH_NUM=2, SAMPLE_W=10, FRAME_SAMPLES=4, BUF_AW=4; tx_byte_num=20.
- Basic frame:
  - Stimulus: 4 vectors {ch1=10'h3FF, ch0=10'h001} 10 cycles apart; UDP model with continuous tx_req.
  - Required: one tx_start_en; bytes A5 5A 00 00 then (00 01 03 FF)×4; after tx_done, seq=1, busy=0.
- Back-to-back drop:
  - Stimulus: s_valid on 2 consecutive cycles.
  - Required: the second vector is dropped; ovf_cnt=1; level=2.
- Full buffer:
  - Stimulus: tx_req held low, 9 vectors sent.
  - Required: 8 accepted, ovf_cnt=1, still one frame pending.
- Over-request and early done:
  - Stimulus 1: 25 tx_req cycles.
  - Required: bytes 21–25 read 00, rd_ptr advances by 8 only.
  - Stimulus 2: tx_done after 10 bytes.
  - Required: FSM returns to IDLE, rd_ptr at frame end.
- Reset during SEND:
  - Stimulus: rst asserted mid-SEND.
  - Required: all outputs at reset values within the same cycle; the next frame header reports seq 00 00.
- Pattern mode:
  - Stimulus: macro defined, 4 vectors.
  - Required: payload 00 00 10 00 00 01 10 01 00 02 10 02 00 03 10 03.

Source files
------------

// File: rtl/adc_udp_packer.sv
// Multi-channel ADC sample packer: buffers channel-interleaved 16-bit words and serves them as UDP payload bytes.
// Optional build macro ADC_UDP_PACKER_PATTERN_EN replaces sample data with a {channel, ramp} test pattern.
module adc_udp_packer #(
    parameter int CH_NUM        = 2,
    parameter int SAMPLE_W      = 10,
    parameter int FRAME_SAMPLES = 256,
    parameter int BUF_AW        = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         s_valid,
    input  logic [CH_NUM*SAMPLE_W-1:0]   s_data,
    output logic                         tx_start_en,
    output logic [15:0]                  tx_byte_num,
    input  logic                         tx_req,
    output logic [7:0]                   tx_data,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [15:0]                  seq,
    output logic [15:0]                  ovf_cnt,
    output logic [1:0]                   dbg_state
);
    localparam int DEPTH       = 1 << BUF_AW;
    localparam int FRAME_WORDS = CH_NUM * FRAME_SAMPLES;
    localparam int BYTE_NUM    = 4 + 2 * FRAME_WORDS;
    localparam int CIW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, SEND = 2'd2, WAIT_DONE = 2'd3} state_t;

    // Handshake: an s_valid cycle is accepted or dropped in that cycle; a tx_req cycle in SEND yields tx_data on the next cycle.
    state_t              state;
    logic [BUF_AW:0]     wr_ptr, rd_ptr, level, pend, frm_end, rd_ptr_nxt;
    logic                wr_busy, wr_last, room, accept, drop, frame_ready;
    logic [CIW-1:0]      wr_idx;
    logic [BUF_AW-1:0]   waddr;
    logic [15:0]         wr_word, cur_word, bcnt;
    logic [7:0]          byte_sel;
    logic [15:0]         mem [DEPTH];

`ifdef ADC_UDP_PACKER_PATTERN_EN
    logic [11:0]         ramp, ramp_hold;
    logic                unused_data;
    assign unused_data = ^s_data;
`else
    logic [CH_NUM*SAMPLE_W-1:0] hold;
`endif

    assign tx_byte_num = 16'(BYTE_NUM);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;
    assign level       = wr_ptr - rd_ptr;
    // Words of a vector still being serialised count as occupied so a new vector never overruns.
    assign pend        = level + (wr_busy ? (BUF_AW+1)'(CH_NUM) : '0);
    assign room        = (int'(pend) + CH_NUM) <= DEPTH;
    assign wr_last     = wr_busy && (wr_idx == CIW'(CH_NUM - 1));
    assign accept      = s_valid && en && (!wr_busy || wr_last) && room;
    assign drop        = s_valid && en && !accept;
    assign waddr       = wr_ptr[BUF_AW-1:0] + BUF_AW'(wr_idx);
    assign rd_ptr_nxt  = rd_ptr + 1'b1;

    always_comb begin
        wr_word = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (wr_idx == CIW'(c)) begin
`ifdef ADC_UDP_PACKER_PATTERN_EN
                wr_word = {4'(c), ramp_hold};
`else
                wr_word = 16'(hold[c*SAMPLE_W +: SAMPLE_W]);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_busy <= 1'b0;
            wr_idx  <= '0;
            ovf_cnt <= '0;
`ifdef ADC_UDP_PACKER_PATTERN_EN
            ramp      <= '0;
            ramp_hold <= '0;
`else
            hold    <= '0;
`endif
        end else begin
            // The vector becomes visible in level only once its last word is in RAM.
            if (wr_last)
                wr_ptr <= wr_ptr + (BUF_AW+1)'(CH_NUM);
            if (accept) begin
                wr_busy <= 1'b1;
                wr_idx  <= '0;
`ifdef ADC_UDP_PACKER_PATTERN_EN
                ramp_hold <= ramp;
                ramp      <= ramp + 1'b1;
`else
                hold    <= s_data;
`endif
            end else if (wr_last) begin
                wr_busy <= 1'b0;
            end else if (wr_busy) begin
                wr_idx  <= wr_idx + 1'b1;
            end
            if (drop && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_busy)
            mem[waddr] <= wr_word;
    end

    always_comb begin
        case (bcnt)
            16'd0:   byte_sel = 8'hA5;
            16'd1:   byte_sel = 8'h5A;
            16'd2:   byte_sel = seq[15:8];
            16'd3:   byte_sel = seq[7:0];
            default: byte_sel = bcnt[0] ? cur_word[7:0] : cur_word[15:8];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            frm_end     <= '0;
            cur_word    <= '0;
            bcnt        <= '0;
            seq         <= '0;
            tx_start_en <= 1'b0;
            tx_data     <= '0;
            frame_ready <= 1'b0;
        end else begin
            tx_start_en <= 1'b0;
            tx_data     <= '0;
            // Only evaluated in IDLE so a stale compare cannot relaunch right after an early tx_done.
            frame_ready <= (state == IDLE) && (int'(level) >= FRAME_WORDS);
            case (state)
                IDLE: begin
                    if (frame_ready) begin
                        state       <= START;
                        tx_start_en <= 1'b1;
                    end
                end
                START: begin
                    cur_word <= mem[rd_ptr[BUF_AW-1:0]];
                    frm_end  <= rd_ptr + (BUF_AW+1)'(FRAME_WORDS);
                    bcnt     <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_done) begin
                        rd_ptr <= frm_end;
                        seq    <= seq + 1'b1;
                        state  <= IDLE;
                    end else if (tx_req) begin
                        tx_data <= byte_sel;
                        bcnt    <= bcnt + 1'b1;
                        // Low byte finishes a word: step the pointer and fetch the next one.
                        if (bcnt >= 16'd4 && bcnt[0]) begin
                            rd_ptr   <= rd_ptr_nxt;
                            cur_word <= mem[rd_ptr_nxt[BUF_AW-1:0]];
                        end
                        if (bcnt == 16'(BYTE_NUM - 1))
                            state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        seq   <= seq + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
